// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's instruction-memory bus, the hazard/redirect
// controls and the IF/ID head outputs. The fetch stage takes the master
// side; the surrounding pipeline and memory take the slave side.
interface fetch_stage_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;
    logic             StallF;
    logic             PCSrcE;
    logic [WIDTH-1:0] PCTargetE;
    logic             ValidF;
    logic [WIDTH-1:0] InstrF;
    logic [WIDTH-1:0] PCF;
    logic [WIDTH-1:0] PCPlus4F;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        input  StallF, PCSrcE, PCTargetE,
        output ValidF, InstrF, PCF, PCPlus4F
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        output StallF, PCSrcE, PCTargetE,
        input  ValidF, InstrF, PCF, PCPlus4F
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps the fetch PC, issues one request at a time
// to a variable-latency instruction memory, and queues returned words in a
// small FIFO whose head feeds the IF/ID register. A redirect from Execute
// flushes the queue and discards any response still in flight.
module fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [WIDTH-1:0] FOUR   = WIDTH'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] pc_fetch;
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             req;
    logic             push;
    logic             pop;
    logic             head_vld;

    assign head_vld = (count != '0);
    assign pop      = head_vld && !bus.StallF && !bus.PCSrcE;

    // Next-state and request/push decode; a redirect overrides everything.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        push    = 1'b0;
        if (bus.PCSrcE) begin
            case (state_q)
                WAIT:    state_d = bus.imem_rvalid ? IDLE : DROP;
                DROP:    state_d = bus.imem_rvalid ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    // Full check deliberately ignores a same-cycle pop.
                    if (rst_n && (count < FULL_CNT)) begin
                        req     = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end
                DROP: begin
                    if (bus.imem_rvalid) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch PC: load redirect target (word aligned) or advance on accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_fetch <= RESET_PC;
        end else if (bus.PCSrcE) begin
            pc_fetch <= {bus.PCTargetE[WIDTH-1:2], 2'b00};
        end else if (push) begin
            pc_fetch <= pc_fetch + FOUR;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.PCSrcE) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]    <= pc_fetch;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = req ? pc_fetch : '0;
    assign bus.ValidF    = head_vld;
    assign bus.InstrF    = head_vld ? instr_mem[rd_ptr] : '0;
    assign bus.PCF       = head_vld ? pc_mem[rd_ptr] : '0;
    assign bus.PCPlus4F  = head_vld ? (pc_mem[rd_ptr] + FOUR) : '0;
endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed per-cycle vector tables, a hand-written
// reset-during-request sequence, and a randomized run checked against a
// program-order stream model.
module tb_fetch_stage;
    logic clk;
    logic rst_n;

    fetch_stage_if #(.WIDTH(32)) bus ();

    fetch_stage #(
        .WIDTH   (32),
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        int          lat;
        bit          stall;
        bit          pcsrc;
        logic [31:0] tgt;
        bit          req;
        logic [31:0] addr;
        bit          vld;
        logic [31:0] pcf;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    // memory responder state
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          cur_lat;
    bit          random_mode;

    // sampled DUT outputs
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_vld;
    logic [31:0] s_instr;
    logic [31:0] s_pcf;
    logic [31:0] s_pc4;
    logic        s_rvalid;
    bit          s_pend;

    function automatic logic [31:0] ifunc(logic [31:0] a);
        return (a * 32'd3) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(bit r, int l, bit st, bit ps, logic [31:0] tg,
                       bit rq, logic [31:0] ad, bit vl, logic [31:0] pc);
        vec_t e;
        e.rst = r; e.lat = l; e.stall = st; e.pcsrc = ps; e.tgt = tg;
        e.req = rq; e.addr = ad; e.vld = vl; e.pcf = pc;
        vecs.push_back(e);
    endtask

    task automatic mem_update();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        if (s_req) begin
            mem_pend = 1'b1;
            mem_cnt  = random_mode ? int'($urandom_range(1, 4)) : cur_lat;
            mem_addr = s_addr;
        end
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = ifunc(mem_addr);
                mem_pend        = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_req    = bus.imem_req;
        s_addr   = bus.imem_addr;
        s_vld    = bus.ValidF;
        s_instr  = bus.InstrF;
        s_pcf    = bus.PCF;
        s_pc4    = bus.PCPlus4F;
        s_rvalid = bus.imem_rvalid;
        s_pend   = mem_pend;
        @(posedge clk);
        #1;
        mem_update();
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.StallF      = 1'b0;
        bus.PCSrcE      = 1'b0;
        bus.PCTargetE   = 32'h0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        mem_pend        = 1'b0;
        mem_cnt         = 0;
        s_req           = 1'b0;
        @(negedge clk);
        chk("rst_req",   32'(bus.imem_req), 32'h0);
        chk("rst_addr",  bus.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus.ValidF), 32'h0);
        chk("rst_head",  bus.InstrF | bus.PCF | bus.PCPlus4F, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_head(string tag, bit vld, logic [31:0] pcf);
        chk({tag, "_valid"}, 32'(s_vld), 32'(vld));
        if (vld) begin
            chk({tag, "_pcf"},   s_pcf,   pcf);
            chk({tag, "_instr"}, s_instr, ifunc(pcf));
            chk({tag, "_pc4"},   s_pc4,   pcf + 32'd4);
        end else begin
            chk({tag, "_zero"}, s_instr | s_pcf | s_pc4, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        bit          after_redir;
        bit          cyc_stall;
        bit          cyc_pcsrc;
        logic [31:0] cyc_tgt;
        int          pops;

        random_mode = 1'b0;
        cur_lat     = 1;
        rst_n       = 1'b0;

        // reset release, latency 1, no stall: request/valid timing
        add(1,1,0,0,32'h0, 1,32'h0, 0,32'h0);
        add(0,1,0,0,32'h0, 0,32'h0, 0,32'h0);
        add(0,1,0,0,32'h0, 1,32'h4, 1,32'h0);
        add(0,1,0,0,32'h0, 0,32'h0, 0,32'h0);
        add(0,1,0,0,32'h0, 1,32'h8, 1,32'h4);
        // stall: fill two entries, hold, then drain in order and resume
        add(1,1,1,0,32'h0, 1,32'h0, 0,32'h0);
        add(0,1,1,0,32'h0, 0,32'h0, 0,32'h0);
        add(0,1,1,0,32'h0, 1,32'h4, 1,32'h0);
        add(0,1,1,0,32'h0, 0,32'h0, 1,32'h0);
        add(0,1,1,0,32'h0, 0,32'h0, 1,32'h0);
        add(0,1,1,0,32'h0, 0,32'h0, 1,32'h0);
        add(0,1,0,0,32'h0, 0,32'h0, 1,32'h0);
        add(0,1,0,0,32'h0, 1,32'h8, 1,32'h4);
        add(0,1,0,0,32'h0, 0,32'h0, 0,32'h0);
        add(0,1,0,0,32'h0, 1,32'hC, 1,32'h8);
        // redirect while waiting, response 3 cycles after request is dropped
        add(1,3,0,0,32'h0,   1,32'h0,   0,32'h0);
        add(0,3,0,1,32'h103, 0,32'h0,   0,32'h0);
        add(0,3,0,0,32'h0,   0,32'h0,   0,32'h0);
        add(0,3,0,0,32'h0,   0,32'h0,   0,32'h0);
        add(0,3,0,0,32'h0,   1,32'h100, 0,32'h0);
        add(0,3,0,0,32'h0,   0,32'h0,   0,32'h0);
        add(0,3,0,0,32'h0,   0,32'h0,   0,32'h0);
        add(0,3,0,0,32'h0,   0,32'h0,   0,32'h0);
        add(0,3,0,0,32'h0,   1,32'h104, 1,32'h100);
        // redirect in the same cycle as the response
        add(1,1,0,0,32'h0,  1,32'h0,  0,32'h0);
        add(0,1,0,1,32'h40, 0,32'h0,  0,32'h0);
        add(0,1,0,0,32'h0,  1,32'h40, 0,32'h0);
        add(0,1,0,0,32'h0,  0,32'h0,  0,32'h0);
        add(0,1,0,0,32'h0,  1,32'h44, 1,32'h40);
        // redirect in IDLE suppresses the request; PC wraps past the top
        add(1,1,0,1,32'hFFFF_FFFC, 0,32'h0,         0,32'h0);
        add(0,1,0,0,32'h0,         1,32'hFFFF_FFFC, 0,32'h0);
        add(0,1,0,0,32'h0,         0,32'h0,         0,32'h0);
        add(0,1,0,0,32'h0,         1,32'h0,         1,32'hFFFF_FFFC);
        add(0,1,0,0,32'h0,         0,32'h0,         0,32'h0);
        add(0,1,0,0,32'h0,         1,32'h4,         1,32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            cur_lat       = vecs[i].lat;
            bus.StallF    = vecs[i].stall;
            bus.PCSrcE    = vecs[i].pcsrc;
            bus.PCTargetE = vecs[i].tgt;
            tick();
            chk($sformatf("v%0d_req", i), 32'(s_req), 32'(vecs[i].req));
            if (vecs[i].req) chk($sformatf("v%0d_addr", i), s_addr, vecs[i].addr);
            check_head($sformatf("v%0d", i), vecs[i].vld, vecs[i].pcf);
        end

        // reset asserted mid-request; a stale response lands in IDLE
        do_reset();
        bus.StallF = 1'b0;
        bus.PCSrcE = 1'b0;
        cur_lat    = 5;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req",   32'(bus.imem_req), 32'h0);
        chk("midrst_valid", 32'(bus.ValidF), 32'h0);
        @(posedge clk);
        #1;
        rst_n           = 1'b1;
        mem_pend        = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        cur_lat         = 1;
        tick();
        chk("stale_req",  32'(s_req), 32'h1);
        chk("stale_addr", s_addr, 32'h0);
        check_head("stale_c0", 1'b0, 32'h0);
        tick();
        check_head("stale_c1", 1'b0, 32'h0);
        tick();
        check_head("stale_c2", 1'b1, 32'h0);

        // randomized run against the program-order stream model
        do_reset();
        random_mode = 1'b1;
        exp_pc      = 32'h0;
        after_redir = 1'b0;
        pops        = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc_stall     = ($urandom_range(0, 9) < 3);
            cyc_pcsrc     = ($urandom_range(0, 19) == 0);
            cyc_tgt       = $urandom;
            bus.StallF    = cyc_stall;
            bus.PCSrcE    = cyc_pcsrc;
            bus.PCTargetE = cyc_tgt;
            tick();
            if (s_req) begin
                chk("rnd_one_outstanding", 32'(s_pend || s_rvalid), 32'h0);
                chk("rnd_req_on_redirect", 32'(cyc_pcsrc), 32'h0);
            end
            if (after_redir) chk("rnd_flush", 32'(s_vld), 32'h0);
            if (!s_vld) begin
                chk("rnd_head_zero", s_instr | s_pcf | s_pc4, 32'h0);
            end else if (!cyc_stall && !cyc_pcsrc) begin
                chk("rnd_pcf",   s_pcf,   exp_pc);
                chk("rnd_instr", s_instr, ifunc(exp_pc));
                chk("rnd_pc4",   s_pc4,   exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (cyc_pcsrc) begin
                exp_pc      = cyc_tgt & 32'hFFFF_FFFC;
                after_redir = 1'b1;
            end else begin
                after_redir = 1'b0;
            end
        end
        chk("rnd_progress", 32'(pops > 200), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Writer side of the IF/ID pipeline register. Generates the fetch PC and issues requests to a variable-latency instruction memory.
- Buffers returned instructions in a small FIFO and presents InstrF/PCF/PCPlus4F with a valid flag to the IF/ID register.
- Honours stall from the hazard unit and branch/jump redirects from Execute, discarding wrong-path fetches.

Parameters:
- WIDTH, 32, data/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, output FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  request strobe, one cycle per request
- imem_addr  out  WIDTH  request address, valid while imem_req=1
- imem_rvalid  in  1  response valid, one cycle
- imem_rdata  in  WIDTH  instruction word, valid with imem_rvalid
- StallF  in  1  IF/ID not accepting this cycle
- PCSrcE  in  1  redirect request from Execute
- PCTargetE  in  WIDTH  redirect target
- ValidF  out  1  FIFO head valid
- InstrF  out  WIDTH  head instruction
- PCF  out  WIDTH  head PC
- PCPlus4F  out  WIDTH  head PC+4

Behaviour:
- Reset (async assert, sync-effective deassert): pc_fetch=RESET_PC, FIFO empty, state=IDLE. Outputs: imem_req=0, imem_addr=0, ValidF=0, InstrF/PCF/PCPlus4F=0.
- Head outputs: ValidF = FIFO non-empty. InstrF/PCF/PCPlus4F show the head entry when ValidF=1, otherwise 0.
- Pop occurs when ValidF=1 and StallF=0 and PCSrcE=0.
- At most one memory request is outstanding.
- State machine: IDLE, WAIT, DROP.
  - IDLE: if PCSrcE=0 and FIFO count<DEPTH, assert imem_req with imem_addr=pc_fetch and go to WAIT. Otherwise imem_req=0. The count check ignores any same-cycle pop.
  - WAIT, imem_rvalid=1, PCSrcE=0: push {imem_rdata, pc_fetch, pc_fetch+4}; pc_fetch+=4; go to IDLE.
  - WAIT, PCSrcE=1, imem_rvalid=0: go to DROP.
  - WAIT, PCSrcE=1, imem_rvalid=1: discard the response; go to IDLE.
  - DROP: stay until imem_rvalid=1, then discard the response and go to IDLE. A PCSrcE arriving in DROP only updates pc_fetch.
  - imem_rvalid in IDLE is ignored.
- Redirect (PCSrcE=1) has top priority in every state:
  - pc_fetch <= {PCTargetE[WIDTH-1:2], 2'b00}.
  - FIFO flushed, so ValidF=0 the next cycle.
  - No pop and no push that cycle.
  - No imem_req that cycle, even in IDLE.
- Latency, with a one-cycle memory and no stall:
  - Request at cycle t, response at t+1, ValidF=1 at t+2, next request at t+2.
  - Steady state is one instruction per 2 cycles.
- FIFO full with StallF=1: no new request; the head holds stable indefinitely.
- Arithmetic: pc_fetch+4 is WIDTH bits and wraps modulo 2^WIDTH (0xFFFF_FFFC -> 0x0000_0000).
- Reset asserted mid-request: state returns to IDLE immediately. Any later stale imem_rvalid arrives in IDLE and is ignored.

Test Plan:
- Reset release with RESET_PC=0, memory latency 1, StallF=0 -> imem_req at cycle 0 addr 0x0. ValidF at cycle 2 with PCF=0x0, PCPlus4F=0x4. Next request addr 0x4 at cycle 2.
- StallF=1 held, latency 1 -> two entries fill (PCs 0x0, 0x4), then imem_req stays 0 and head PCF=0x0 stays stable. Release StallF -> pops in order 0x0, 0x4, then fetching resumes at 0x8.
- PCSrcE=1, PCTargetE=0x103 while WAIT and response 3 cycles later -> that response is dropped, FIFO flushed. Next request addr 0x100; the first valid head shows PCF=0x100.
- PCSrcE=1 in the same cycle as imem_rvalid -> no push, ValidF=0 next cycle. Next imem_addr = target, and the request issues one cycle after the redirect.
- Fetch at 0xFFFF_FFFC -> PCPlus4F=0x0 and the next request addr is 0x0.
- Assert rst_n=0 while WAIT, then release; a stale imem_rvalid arrives in IDLE -> ignored, ValidF=0, first request addr RESET_PC.
